mod241_stream_ctrl: RTL and testbench



---
 rtl/mod241_pkg.sv | 28 ++
 rtl/mod241_fold.sv | 13 +
 rtl/mod241_stream_ctrl.sv | 103 ++++++++++
 tb/tb_mod241_stream_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mod241_pkg.sv
// Shared constants, state encoding and residue-weight lookup for the mod-241 stream controller.
package mod241_pkg;

  localparam int MOD   = 241;
  localparam int W1    = 15;
  localparam int W2    = 225;
  localparam int ACC_W = 22;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    F1,
    F2,
    F3,
    CORR,
    DONE
  } state_t;

  // 2^(8k) mod 241 repeats with period three: 1, 15, 225.
  function automatic logic [ACC_W-1:0] weight(input logic [1:0] idx);
    case (idx)
      2'd1:    weight = ACC_W'(W1);
      2'd2:    weight = ACC_W'(W2);
      default: weight = ACC_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/mod241_fold.sv
// One combinational fold step: re-weights the upper accumulator bytes by their residues mod 241.
module mod241_fold
  import mod241_pkg::*;
(
  input  logic [ACC_W-1:0] acc_in,
  output logic [ACC_W-1:0] acc_out
);

  assign acc_out = ACC_W'(acc_in[7:0])
                 + ACC_W'(acc_in[15:8])  * ACC_W'(W1)
                 + ACC_W'(acc_in[21:16]) * ACC_W'(W2);

endmodule

// File: rtl/mod241_stream_ctrl.sv
// Serial mod-241 reducer: accumulates weighted LSB-first bytes, folds three times, then corrects once.
// Optional early termination via in_last when MOD241_CTRL_LAST_EN is defined.
module mod241_stream_ctrl
  import mod241_pkg::*;
#(
  parameter int NBYTES = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
`ifdef MOD241_CTRL_LAST_EN
  input  logic       in_last,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_res,
  output logic       busy
);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] fold_out;
  logic [5:0]       cnt;
  logic [1:0]       widx;
  logic             accept;
  logic             last_byte;
  logic             restart;

  mod241_fold u_fold (
    .acc_in  (acc),
    .acc_out (fold_out)
  );

  assign accept = in_valid && in_ready;

`ifdef MOD241_CTRL_LAST_EN
  assign last_byte = (cnt == 6'(NBYTES - 1)) || in_last;
`else
  assign last_byte = (cnt == 6'(NBYTES - 1));
`endif

  // A new operand may only begin from IDLE or on the DONE output handshake.
  assign restart = start && ((state == IDLE) || ((state == DONE) && out_ready));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && last_byte) state_nxt = F1;
      end
      F1:   state_nxt = F2;
      F2:   state_nxt = F3;
      F3:   state_nxt = CORR;
      CORR: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = start ? ACCUM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // After three folds acc is at most 330, so a single conditional subtract lands in 0..240.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      widx    <= '0;
      out_res <= '0;
    end else begin
      if (restart) begin
        acc  <= '0;
        cnt  <= '0;
        widx <= '0;
      end else if (accept) begin
        acc  <= acc + ACC_W'(in_data) * weight(widx);
        cnt  <= cnt + 6'd1;
        widx <= (widx == 2'd2) ? 2'd0 : widx + 2'd1;
      end else if ((state == F1) || (state == F2) || (state == F3)) begin
        acc <= fold_out;
      end
      if (state == CORR)
        out_res <= (acc >= ACC_W'(MOD)) ? 8'(acc - ACC_W'(MOD)) : acc[7:0];
    end
  end

endmodule

// File: tb/tb_mod241_stream_ctrl.sv
// Directed self-checking bench for mod241_stream_ctrl (NBYTES=50); covers in_last when MOD241_CTRL_LAST_EN is defined.
module tb_mod241_stream_ctrl;

  localparam int NB = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
`ifdef MOD241_CTRL_LAST_EN
  logic       in_last;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] op [0:NB-1];

  mod241_stream_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef MOD241_CTRL_LAST_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_op(input logic [7:0] fill, input int idx, input logic [7:0] val);
    for (int k = 0; k < NB; k++) op[k] = fill;
    if (idx >= 0) op[idx] = val;
  endtask

  task automatic begin_op(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check_output({tag, "_in_ready_after_start"}, 32'(in_ready), 32'd1);
  endtask

  // Gap cycles drive junk data with in_valid low; it must not be consumed.
  task automatic send_bytes(input int n, input bit gap, input int spur);
    for (int k = 0; k < n; k++) begin
      if (gap) begin
        in_valid = 1'b0;
        in_data  = 8'hAA;
        step();
      end
      in_valid = 1'b1;
      in_data  = op[k];
      start    = (k == spur);
      if (k == 0 || k == n - 1) check_output("in_ready_accum", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Four edges after the last-accept edge means out_valid in cycle last+5.
  task automatic wait_result(input string tag, input logic [7:0] exp);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check_output({tag, "_latency"}, 32'(lat), 32'd4);
    check_output({tag, "_out_res"}, 32'(out_res), 32'(exp));
  endtask

  task automatic finish_handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_output({tag, "_out_valid_after_hs"}, 32'(out_valid), 32'd0);
    check_output({tag, "_busy_after_hs"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
`ifdef MOD241_CTRL_LAST_EN
    in_last = 1'b0;
`endif
    step(); step();
    rst_n = 1'b1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_res", 32'(out_res), 32'd0);

    $display("[TB] all-zero operand");
    fill_op(8'h00, -1, 8'h00);
    begin_op("zero"); send_bytes(NB, 1'b0, -1); wait_result("zero", 8'd0); finish_handshake("zero");

    $display("[TB] single-byte weights");
    fill_op(8'h00, 0, 8'd241);
    begin_op("b0_241"); send_bytes(NB, 1'b0, -1); wait_result("b0_241", 8'd0); finish_handshake("b0_241");
    fill_op(8'h00, 1, 8'h01);
    begin_op("b1_1"); send_bytes(NB, 1'b0, -1); wait_result("b1_1", 8'd15); finish_handshake("b1_1");
    fill_op(8'h00, 2, 8'h01);
    begin_op("b2_1"); send_bytes(NB, 1'b0, -1); wait_result("b2_1", 8'd225); finish_handshake("b2_1");

    $display("[TB] all-ones operand, back-to-back and gapped");
    fill_op(8'hFF, -1, 8'h00);
    begin_op("ff"); send_bytes(NB, 1'b0, -1); wait_result("ff", 8'd224); finish_handshake("ff");
    in_valid = 1'b1; in_data = 8'hFF;
    step(); step();
    check_output("idle_in_ready", 32'(in_ready), 32'd0);
    check_output("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    begin_op("ff_gap"); send_bytes(NB, 1'b1, -1); wait_result("ff_gap", 8'd224); finish_handshake("ff_gap");

    $display("[TB] spurious start, backpressure, start on handshake");
    fill_op(8'h00, 1, 8'h01);
    begin_op("bp"); send_bytes(NB, 1'b0, 10); wait_result("bp", 8'd15);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("bp_hold_valid", 32'(out_valid), 32'd1);
      check_output("bp_hold_res", 32'(out_res), 32'd15);
    end
    fill_op(8'hFF, -1, 8'h00);
    out_ready = 1'b1; start = 1'b1;
    step();
    out_ready = 1'b0; start = 1'b0;
    check_output("hs_start_in_ready", 32'(in_ready), 32'd1);
    check_output("hs_start_out_valid", 32'(out_valid), 32'd0);
    send_bytes(NB, 1'b0, -1); wait_result("hs_op2", 8'd224); finish_handshake("hs_op2");

    $display("[TB] reset mid-operand");
    fill_op(8'hFF, -1, 8'h00);
    begin_op("mid"); send_bytes(20, 1'b0, -1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_output("mid_rst_busy", 32'(busy), 32'd0);
    check_output("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check_output("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_output("mid_rst_out_res", 32'(out_res), 32'd0);
    fill_op(8'h00, 2, 8'h01);
    begin_op("post_rst"); send_bytes(NB, 1'b0, -1); wait_result("post_rst", 8'd225); finish_handshake("post_rst");

`ifdef MOD241_CTRL_LAST_EN
    $display("[TB] early termination with in_last");
    fill_op(8'h00, 0, 8'h01);
    op[2] = 8'h01;
    begin_op("last");
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = op[k]; in_last = (k == 2);
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_result("last", 8'd226); finish_handshake("last");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
